// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard/stall unit: FSM encodings, control bundle,
// default control values and the load-use compare.
package hazard_stall_unit_pkg;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned TIMER_WIDTH = 8;

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_BUSY = 1'b1;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } hazard_ctrl_t;

    // Pipeline runs freely, nothing squashed.
    localparam hazard_ctrl_t CTRL_DEFAULT = '{
        pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0
    };

    // Front end held while mul/div occupies EX; EX/MEM gets bubbles.
    localparam hazard_ctrl_t CTRL_FREEZE = '{
        pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b1
    };

    // Hold IF and ID, insert one bubble into ID/EX.
    localparam hazard_ctrl_t CTRL_BUBBLE = '{
        pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b1, ex_mem_flush: 1'b0
    };

    // Squash the wrong-path instructions in IF/ID and ID/EX; fetch the target.
    localparam hazard_ctrl_t CTRL_BRANCH = '{
        pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b0
    };

    function automatic logic load_use_hit(
        input logic                  mem_read,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic [REG_ADDR_W-1:0] rs2,
        input logic                  uses_rs1,
        input logic                  uses_rs2
    );
        return mem_read && (rd != '0) &&
               ((uses_rs1 && (rd == rs1)) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/muldiv_stall_timer.sv
// Down-counter tracking the remaining frozen cycles of a mul/div op in EX.
module muldiv_stall_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_c
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage core: load-use bubbles, taken-branch
// squash, mul/div front-end freeze and a saturating stall-cycle counter.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MULDIV_LATENCY = 4,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] IF_ID_Rs1,
    input  logic [REG_ADDR_W-1:0] IF_ID_Rs2,
    input  logic                  IF_ID_uses_rs1,
    input  logic                  IF_ID_uses_rs2,
    input  logic                  ID_EX_mem_read,
    input  logic [REG_ADDR_W-1:0] ID_EX_Rd,
    input  logic                  EX_branch_taken,
    input  logic                  EX_muldiv,
    output logic                  PC_write,
    output logic                  IF_ID_write,
    output logic                  ID_EX_write,
    output logic                  IF_ID_flush,
    output logic                  ID_EX_flush,
    output logic                  EX_MEM_flush,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    // The op's first EX cycle is spent in RUN and its last in MD_BUSY at zero.
    localparam logic [TIMER_WIDTH-1:0] TIMER_LOAD = TIMER_WIDTH'(MULDIV_LATENCY - 2);

    logic [0:0]           state_q;
    logic [0:0]           state_d;
    logic                 busy_q;
    logic                 busy_d;
    logic [CNT_WIDTH-1:0] stall_count_q;
    logic [CNT_WIDTH-1:0] stall_count_d;

    hazard_ctrl_t ctrl_c;
    logic         load_use_c;
    logic         timer_load_c;
    logic         timer_dec_c;
    logic         timer_zero_c;

    assign load_use_c = load_use_hit(ID_EX_mem_read, ID_EX_Rd, IF_ID_Rs1, IF_ID_Rs2,
                                     IF_ID_uses_rs1, IF_ID_uses_rs2);

    muldiv_stall_timer #(
        .WIDTH (TIMER_WIDTH)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load_c),
        .load_val_i (TIMER_LOAD),
        .dec_i      (timer_dec_c),
        .zero_c     (timer_zero_c)
    );

    // Next state and control outputs.
    always_comb begin
        ctrl_c       = CTRL_DEFAULT;
        state_d      = state_q;
        timer_load_c = 1'b0;
        timer_dec_c  = 1'b0;
        if (rst) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (EX_branch_taken) begin
                        ctrl_c = CTRL_BRANCH;
                    end else if (EX_muldiv) begin
                        ctrl_c       = CTRL_FREEZE;
                        state_d      = ST_MD_BUSY;
                        timer_load_c = 1'b1;
                    end else if (load_use_c) begin
                        ctrl_c = CTRL_BUBBLE;
                    end
                end
                ST_MD_BUSY: begin
                    // Zero means the op's final EX cycle: release without
                    // retriggering on the still-high EX_muldiv level.
                    if (!timer_zero_c) begin
                        ctrl_c      = CTRL_FREEZE;
                        timer_dec_c = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Registered status: busy mirrors the next state, counter saturates.
    always_comb begin
        busy_d        = (state_d == ST_MD_BUSY);
        stall_count_d = stall_count_q;
        if (rst) begin
            stall_count_d = '0;
        end else if (!ctrl_c.pc_write && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            busy_q        <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign PC_write     = ctrl_c.pc_write;
    assign IF_ID_write  = ctrl_c.if_id_write;
    assign ID_EX_write  = ctrl_c.id_ex_write;
    assign IF_ID_flush  = ctrl_c.if_id_flush;
    assign ID_EX_flush  = ctrl_c.id_ex_flush;
    assign EX_MEM_flush = ctrl_c.ex_mem_flush;
    assign busy         = busy_q;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: a 32-bit-counter instance and a
// 4-bit-counter instance share stimulus and are checked against one model.
module tb_hazard_stall_unit;

    localparam int unsigned LAT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, br, md;

    logic        a_pc, a_ifw, a_idw, a_iff, a_idf, a_exf, a_busy;
    logic [31:0] a_cnt;
    logic        b_pc, b_ifw, b_idw, b_iff, b_idf, b_exf, b_busy;
    logic [3:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MULDIV_LATENCY(LAT), .CNT_WIDTH(32)) dut_a (
        .clk(clk), .rst(rst),
        .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2), .IF_ID_uses_rs1(u1), .IF_ID_uses_rs2(u2),
        .ID_EX_mem_read(mr), .ID_EX_Rd(rd), .EX_branch_taken(br), .EX_muldiv(md),
        .PC_write(a_pc), .IF_ID_write(a_ifw), .ID_EX_write(a_idw),
        .IF_ID_flush(a_iff), .ID_EX_flush(a_idf), .EX_MEM_flush(a_exf),
        .busy(a_busy), .stall_count(a_cnt)
    );

    hazard_stall_unit #(.MULDIV_LATENCY(LAT), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst),
        .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2), .IF_ID_uses_rs1(u1), .IF_ID_uses_rs2(u2),
        .ID_EX_mem_read(mr), .ID_EX_Rd(rd), .EX_branch_taken(br), .EX_muldiv(md),
        .PC_write(b_pc), .IF_ID_write(b_ifw), .ID_EX_write(b_idw),
        .IF_ID_flush(b_iff), .ID_EX_flush(b_idf), .EX_MEM_flush(b_exf),
        .busy(b_busy), .stall_count(b_cnt)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: op_cycle counts how far into a mul/div op EX is (0 = no op);
    // total is the unbounded number of stalled cycles since reset.
    int     op_cycle = 0;
    longint total    = 0;

    initial begin : compare
        logic   lu;
        logic   e_pc, e_ifw, e_idw, e_iff, e_idf, e_exf;
        longint sat;
        @(posedge clk);
        forever begin
            @(negedge clk);
            lu = mr && (rd != 5'd0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
            {e_pc, e_ifw, e_idw, e_iff, e_idf, e_exf} = 6'b111000;
            if (!rst) begin
                if (op_cycle == 0) begin
                    if (br)      {e_iff, e_idf} = 2'b11;
                    else if (md) {e_pc, e_ifw, e_idw, e_exf} = 4'b0001;
                    else if (lu) {e_pc, e_ifw, e_idf} = 3'b001;
                end else if (op_cycle < int'(LAT) - 1) begin
                    {e_pc, e_ifw, e_idw, e_exf} = 4'b0001;
                end
            end
            sat = (total > 15) ? 15 : total;
            chk("ctrl_a", {a_pc, a_ifw, a_idw, a_iff, a_idf, a_exf},
                {e_pc, e_ifw, e_idw, e_iff, e_idf, e_exf});
            chk("ctrl_b", {b_pc, b_ifw, b_idw, b_iff, b_idf, b_exf},
                {e_pc, e_ifw, e_idw, e_iff, e_idf, e_exf});
            chk("busy_a", a_busy, op_cycle != 0);
            chk("busy_b", b_busy, op_cycle != 0);
            chk("cnt_a", a_cnt, total);
            chk("cnt_b", b_cnt, sat);
            if (rst) begin
                op_cycle = 0;
                total    = 0;
            end else begin
                if (op_cycle == 0) op_cycle = (!br && md) ? 1 : 0;
                else               op_cycle = (op_cycle == int'(LAT) - 1) ? 0 : op_cycle + 1;
                if (!e_pc) total++;
            end
        end
    end

    task automatic apply(input logic r, input logic m_r, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2,
                         input logic us1, input logic us2, input logic b, input logic m);
        rst = r; mr = m_r; rd = d; rs1 = s1; rs2 = s2; u1 = us1; u2 = us2; br = b; md = m;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        // Reset with hazard-looking inputs: outputs must stay at defaults.
        apply(1, 1, 5, 5, 0, 1, 0, 0, 1);
        #2;
        chk("rst_pc", a_pc, 1);
        chk("rst_exf", a_exf, 0);
        tick(); tick();
        idle();
        #2;
        chk("rst_cnt", a_cnt, 0);
        chk("rst_busy", a_busy, 0);
        tick();

        // Load-use: lw x5 in EX, ID reads x5 via rs1.
        apply(0, 1, 5, 5, 0, 1, 0, 0, 0);
        #2;
        chk("lu_pc", a_pc, 0);
        chk("lu_ifw", a_ifw, 0);
        chk("lu_idf", a_idf, 1);
        tick();
        idle();
        #2;
        chk("lu_cnt", a_cnt, 1);
        chk("lu_after_pc", a_pc, 1);
        tick();

        // x0 destination and unused rs2 never stall.
        apply(0, 1, 0, 0, 0, 1, 0, 0, 0);
        #2;
        chk("x0_pc", a_pc, 1);
        tick();
        apply(0, 1, 7, 0, 7, 0, 0, 0, 0);
        #2;
        chk("nouse_pc", a_pc, 1);
        tick();

        // Taken branch with coincident load-use: squash, no stall.
        apply(0, 1, 5, 5, 0, 1, 0, 1, 0);
        #2;
        chk("br_iff", a_iff, 1);
        chk("br_idf", a_idf, 1);
        chk("br_pc", a_pc, 1);
        tick();
        idle();
        #2;
        chk("br_cnt", a_cnt, 1);
        tick();

        // Mul/div held four cycles; a branch in cycle 1 is ignored.
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #2; chk("md0_pc", a_pc, 0); chk("md0_exf", a_exf, 1); tick();
        apply(0, 1, 5, 5, 0, 1, 0, 1, 1);
        #2; chk("md1_pc", a_pc, 0); chk("md1_busy", a_busy, 1); chk("md1_iff", a_iff, 0); tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #2; chk("md2_pc", a_pc, 0); tick();
        #2; chk("md3_pc", a_pc, 1); chk("md3_busy", a_busy, 1); chk("md3_exf", a_exf, 0); tick();
        idle();
        #2; chk("md4_busy", a_busy, 0); chk("md4_cnt", a_cnt, 4); tick();

        // Reset in cycle 1 of an op, then a full restart.
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1);
        #2; chk("rmid_pc", a_pc, 1); chk("rmid_exf", a_exf, 0); tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2; chk("rmid_busy", a_busy, 0); chk("rmid_cnt", a_cnt, 0); tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (LAT) tick();
        idle();
        #2; chk("restart_cnt", a_cnt, 3); tick();

        // Mul/div with branch: branch wins, no busy period.
        apply(0, 0, 0, 0, 0, 0, 0, 1, 1);
        #2; chk("mdbr_pc", a_pc, 1); tick();
        idle();
        #2; chk("mdbr_busy", a_busy, 0); tick();

        // Saturation of the 4-bit counter over 20 load-use cycles.
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        apply(0, 1, 9, 0, 9, 0, 1, 0, 0);
        repeat (20) tick();
        idle();
        #2; chk("sat_b", b_cnt, 15); chk("sat_a", a_cnt, 20); tick();

        // Random mix checked by the model every cycle.
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 49) == 0), $urandom_range(0, 1), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
            tick();
        end
        idle();
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Companion to the pipeline forwarding logic. It handles every hazard that forwarding cannot resolve, using stalls and flushes instead of operand bypass.
- Detects load-use hazards between IF/ID and ID/EX, and flushes on a taken branch resolved in EX.
- Freezes the front end while a multi-cycle mul/div occupies EX.
- Counts stall cycles for performance analysis. Sits beside the forwarding unit in the 5-stage RISC-V core and drives the pipeline-register write-enables and flushes.

Parameters:
- MULDIV_LATENCY, 4, total cycles a mul/div op occupies EX; legal range is 2 to 255.
- CNT_WIDTH, 32, width of the stall_count performance counter.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  synchronous reset, active-high
- IF_ID_Rs1  input  5  rs1 of the instruction in ID
- IF_ID_Rs2  input  5  rs2 of the instruction in ID
- IF_ID_uses_rs1  input  1  ID instruction reads rs1
- IF_ID_uses_rs2  input  1  ID instruction reads rs2
- ID_EX_mem_read  input  1  EX instruction is a load
- ID_EX_Rd  input  5  rd of the EX instruction
- EX_branch_taken  input  1  taken branch or jump resolved in EX this cycle
- EX_muldiv  input  1  level signal: ID/EX holds a multi-cycle mul/div op
- PC_write  output  1  PC update enable
- IF_ID_write  output  1  IF/ID register enable
- ID_EX_write  output  1  ID/EX register enable
- IF_ID_flush  output  1  load NOP into IF/ID
- ID_EX_flush  output  1  load NOP into ID/EX
- EX_MEM_flush  output  1  load NOP into EX/MEM
- busy  output  1  state is MD_BUSY
- stall_count  output  CNT_WIDTH  saturating count of cycles with PC_write=0

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- While rst=1:
  - state←RUN, cnt←0, stall_count←0, busy=0.
  - Outputs forced to defaults: all *_write=1, all *_flush=0.
- Defaults: all *_write=1, all *_flush=0. Control outputs are combinational from state and inputs; stall_count and busy are registered.
- load_use = ID_EX_mem_read && ID_EX_Rd!=0 && ((IF_ID_uses_rs1 && ID_EX_Rd==IF_ID_Rs1) || (IF_ID_uses_rs2 && ID_EX_Rd==IF_ID_Rs2)).
- State RUN, priority order:
  1. EX_branch_taken: IF_ID_flush=1, ID_EX_flush=1; PC_write=1 and IF_ID_write=1 (target fetched). A coincident load_use is ignored because the ID instruction is squashed.
  2. EX_muldiv: PC_write=0, IF_ID_write=0, ID_EX_write=0, EX_MEM_flush=1. Next state is MD_BUSY with cnt←MULDIV_LATENCY-2.
  3. load_use: PC_write=0, IF_ID_write=0, ID_EX_flush=1; one bubble, stay in RUN.
  4. Otherwise: defaults.
- EX_muldiv together with EX_branch_taken is illegal; branch wins and no MD_BUSY is entered.
- State MD_BUSY:
  - cnt!=0: same freeze outputs as RUN case 2; cnt←cnt-1. EX_branch_taken and load_use are ignored.
  - cnt==0: final EX cycle of the op. Outputs are defaults; EX_muldiv is ignored so the still-asserted level does not retrigger; next state is RUN.
- Timing result: the op occupies EX for exactly MULDIV_LATENCY cycles, and the front end is frozen for MULDIV_LATENCY-1 cycles.
- stall_count: increments at the clock edge after any cycle with PC_write=0 and rst=0. It holds at all-ones (saturation).
- Reset mid-MD_BUSY: next cycle is RUN with cnt=0. No residual freeze; a still-asserted EX_muldiv restarts a full sequence.
- Rd/Rs of x0 never creates a load-use stall.

Decomposition:
- Shared include hazard_defs.vh holds:
  - state encodings ST_RUN=1'b0, ST_MD_BUSY=1'b1;
  - default-control localparams, shared with the forwarding unit and the core top.
- One natural sub-module: muldiv_stall_timer, an 8-bit down-counter with load, decrement and zero flag. The top keeps the state machine, hazard compare and perf counter.

Test Plan:
- Load-use: lw x5 in EX (mem_read=1, Rd=5); ID has Rs1=5, uses_rs1=1 → one cycle of PC_write=0, IF_ID_write=0, ID_EX_flush=1; stall_count 0→1; next cycle defaults.
- x0 and unused operand:
  - Rd=0 with Rs1=0 → no stall.
  - Rd=7, Rs2=7, uses_rs2=0 → no stall.
- Branch plus load-use: EX_branch_taken=1 with load_use true → IF_ID_flush=1, ID_EX_flush=1, PC_write=1; stall_count unchanged.
- Mul/div, MULDIV_LATENCY=4, EX_muldiv held 4 cycles → freeze (PC_write=0, EX_MEM_flush=1) in cycles 0–2, defaults in cycle 3; busy=1 for cycles 1–3; stall_count=3; state RUN at cycle 4.
- Reset mid-op: assert rst in cycle 1 of a MULDIV_LATENCY=4 op → outputs at defaults while rst=1; busy=0 and stall_count=0 after release.
- Saturation: CNT_WIDTH=4, 20 consecutive load-use cycles → stall_count reaches 15 and holds.
